// File: rtl/cluster_out_drain_pkg.sv
// Shared types, widths and helpers for the cluster output drain.
// Also holds relu_f, which the top uses only when DRAIN_RELU_EN is defined.
package npu_drain_pkg;

  localparam int OUTPUT_BUF_SIZE  = 32;
  localparam int OUTPUT_BUF_NUM   = 32;
  localparam int COMPUTE_UNIT_NUM = 32;
  localparam int OUT_BUS_WORDS    = 2;

  localparam int BUF_IDX_W   = $clog2(OUTPUT_BUF_NUM);
  localparam int UNIT_IDX_W  = $clog2(COMPUTE_UNIT_NUM);
  localparam int BUF_NUM_W   = BUF_IDX_W + 1;
  localparam int SLOT_W      = (OUT_BUS_WORDS > 1) ? $clog2(OUT_BUS_WORDS) : 1;
  localparam int BEAT_DATA_W = OUT_BUS_WORDS * OUTPUT_BUF_SIZE;
  localparam int BEATS_MAX   = OUTPUT_BUF_NUM * COMPUTE_UNIT_NUM / OUT_BUS_WORDS;
  localparam int BEAT_CNT_W  = $clog2(BEATS_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_END,
    FILL,
    PUSH,
    DONE
  } drain_state_e;

  function automatic logic [OUTPUT_BUF_SIZE-1:0] relu_f(input logic [OUTPUT_BUF_SIZE-1:0] w);
    return w[OUTPUT_BUF_SIZE-1] ? '0 : w;
  endfunction

endpackage

// File: rtl/cluster_out_drain_if.sv
// Valid/ready beat stream from the drain toward the writeback/DMA stage.
interface cluster_out_drain_if;
  import npu_drain_pkg::*;

  logic [BEAT_DATA_W-1:0] out_dat_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic                   out_last_o;

  modport master (output out_dat_o, output out_valid_o, output out_last_o, input out_ready_i);
  modport slave  (input out_dat_o, input out_valid_o, input out_last_o, output out_ready_i);

endinterface

// File: rtl/cluster_out_drain_packer.sv
// drain_word_packer: collects words by slot index and holds the completed beat.
module drain_word_packer
  import npu_drain_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_wr_en,
  input  logic [SLOT_W-1:0]          i_slot,
  input  logic [OUTPUT_BUF_SIZE-1:0] i_word,
  output logic [BEAT_DATA_W-1:0]     o_beat
);

  logic [OUTPUT_BUF_SIZE-1:0] r_slot [OUT_BUS_WORDS];
  logic [BEAT_DATA_W-1:0]     r_beat;
  logic [BEAT_DATA_W-1:0]     w_beat_nxt;

  // The final word goes straight into the beat so the beat is ready one cycle later.
  always_comb begin
    w_beat_nxt = '0;
    for (int k = 0; k < OUT_BUS_WORDS; k++) begin
      w_beat_nxt[k*OUTPUT_BUF_SIZE +: OUTPUT_BUF_SIZE] = (k == OUT_BUS_WORDS - 1) ? i_word : r_slot[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_beat <= '0;
      for (int k = 0; k < OUT_BUS_WORDS; k++) begin
        r_slot[k] <= '0;
      end
    end else if (i_wr_en) begin
      if (i_slot == SLOT_W'(OUT_BUS_WORDS - 1)) begin
        r_beat <= w_beat_nxt;
      end else begin
        r_slot[i_slot] <= i_word;
      end
    end
  end

  assign o_beat = r_beat;

endmodule

// File: rtl/cluster_out_drain.sv
// Drains every (buffer, unit) accumulator from the compute cluster into packed beats.
// Define DRAIN_RELU_EN to clamp negative words to zero before packing.
//
// state    | meaning
// IDLE     | waiting for start_i
// WAIT_END | drain armed, waiting for chunk_end_i
// FILL     | reading one word per cycle into the packer
// PUSH     | beat presented, waiting for out_ready_i
// DONE     | one-cycle completion pulse
module cluster_out_drain
  import npu_drain_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       chunk_end_i,
  input  logic [BUF_NUM_W-1:0]       buf_num_i,
  output logic [BUF_IDX_W-1:0]       out_buf_sel_o,
  output logic [UNIT_IDX_W-1:0]      com_unit_out_buf_sel_o,
  input  logic [OUTPUT_BUF_SIZE-1:0] out_buf_dat_i,
  cluster_out_drain_if.master        out_if,
  output logic                       busy_o,
  output logic                       done_o
);

  drain_state_e r_state, w_state_nxt;

  logic [BUF_IDX_W-1:0]       r_b;
  logic [UNIT_IDX_W-1:0]      r_u;
  logic [BEAT_CNT_W-1:0]      r_beats_left;
  logic [BUF_NUM_W-1:0]       w_buf_sat;
  logic [BEAT_CNT_W-1:0]      w_beats_total;
  logic [SLOT_W-1:0]          w_slot;
  logic                       w_fill;
  logic                       w_slot_last;
  logic                       w_hs;
  logic                       w_last_beat;
  logic [OUTPUT_BUF_SIZE-1:0] w_word;

  assign w_buf_sat     = (buf_num_i > BUF_NUM_W'(OUTPUT_BUF_NUM)) ? BUF_NUM_W'(OUTPUT_BUF_NUM) : buf_num_i;
  assign w_beats_total = BEAT_CNT_W'(w_buf_sat) * BEAT_CNT_W'(COMPUTE_UNIT_NUM / OUT_BUS_WORDS);
  assign w_slot        = r_u[SLOT_W-1:0];
  assign w_fill        = (r_state == FILL);
  assign w_slot_last   = w_fill && (w_slot == SLOT_W'(OUT_BUS_WORDS - 1));
  assign w_hs          = (r_state == PUSH) && out_if.out_ready_i;
  assign w_last_beat   = (r_beats_left == BEAT_CNT_W'(1));

`ifdef DRAIN_RELU_EN
  assign w_word = relu_f(out_buf_dat_i);
`else
  assign w_word = out_buf_dat_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (start_i) w_state_nxt = WAIT_END;
      WAIT_END: begin
        if (r_beats_left == '0) w_state_nxt = DONE;
        else if (chunk_end_i)   w_state_nxt = FILL;
      end
      FILL:     if (w_slot_last) w_state_nxt = PUSH;
      PUSH:     if (w_hs) w_state_nxt = w_last_beat ? DONE : FILL;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o             = (r_state == WAIT_END) || (r_state == FILL) || (r_state == PUSH);
    done_o             = (r_state == DONE);
    out_if.out_valid_o = (r_state == PUSH);
    out_if.out_last_o  = (r_state == PUSH) && w_last_beat;
  end

  // Beats-remaining is the terminal count; b/u only steer the read mux.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_b          <= '0;
      r_u          <= '0;
      r_beats_left <= '0;
    end else if (r_state == IDLE) begin
      if (start_i) begin
        r_b          <= '0;
        r_u          <= '0;
        r_beats_left <= w_beats_total;
      end
    end else if (w_fill) begin
      if (r_u == UNIT_IDX_W'(COMPUTE_UNIT_NUM - 1)) begin
        r_u <= '0;
        r_b <= r_b + 1'b1;
      end else begin
        r_u <= r_u + 1'b1;
      end
    end else if (w_hs) begin
      r_beats_left <= r_beats_left - 1'b1;
      if (w_last_beat) begin
        r_b <= '0;
        r_u <= '0;
      end
    end else if (r_state == DONE) begin
      r_b <= '0;
      r_u <= '0;
    end
  end

  assign out_buf_sel_o          = r_b;
  assign com_unit_out_buf_sel_o = r_u;

  drain_word_packer u_packer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_wr_en (w_fill),
    .i_slot  (w_slot),
    .i_word  (w_word),
    .o_beat  (out_if.out_dat_o)
  );

endmodule
